// File: rtl/pa_fdsu_prenorm.sv
// FDSU divide/sqrt operand pre-normalization stage.
// Define FDSU_PRENORM_DUAL_EN to normalize both operands in one cycle.

module pa_fdsu_prenorm_norm (
    input  logic [51:0] frac_num,
    output logic [12:0] frac_bin_val,
    output logic [51:0] fanc_shift_num
);

    logic [5:0] pos;

    // Find the leading one, report its weight and left-justify it to bit 51
    always_comb begin
        pos = 6'd0;
        for (int i = 0; i < 52; i++) begin
            if (frac_num[i]) pos = 6'(i);
        end
        frac_bin_val   = {7'd0, pos} - 13'd51;
        fanc_shift_num = frac_num << (6'd51 - pos);
    end

endmodule

module pa_fdsu_prenorm (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sqrt,
    input  logic        in_double,
    input  logic [63:0] in_src_a,
    input  logic [63:0] in_src_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic        out_sqrt,
    output logic        out_double,
    output logic [12:0] out_exp_a,
    output logic [12:0] out_exp_b,
    output logic [51:0] out_frac_a,
    output logic [51:0] out_frac_b,
    output logic [2:0]  out_cls_a,
    output logic [2:0]  out_cls_b
);

`ifdef FDSU_PRENORM_DUAL_EN
    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, NORM_A, NORM_B, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic        valid_q, valid_d;
    logic        sign_q, sign_d;
    logic        sqrt_q, sqrt_d;
    logic        double_q, double_d;
    logic        sub_a_q, sub_a_d;
    logic        sub_b_q, sub_b_d;
    logic [12:0] exp_a_q, exp_a_d;
    logic [12:0] exp_b_q, exp_b_d;
    logic [51:0] frac_a_q, frac_a_d;
    logic [51:0] frac_b_q, frac_b_d;
    logic [2:0]  cls_a_q, cls_a_d;
    logic [2:0]  cls_b_q, cls_b_d;

    logic [68:0] dec_a, dec_b;
    logic        sgn_a, sgn_b;
    logic [12:0] exp_base;

    // {subnormal, cls, exp, frac}; subnormals keep the raw fraction
    function automatic logic [68:0] classify(input logic dbl,
                                             input logic [63:0] src);
        logic [10:0] e;
        logic [51:0] f;
        logic        e_max;
        logic [12:0] ex;
        e     = dbl ? src[62:52] : {3'd0, src[30:23]};
        f     = dbl ? src[51:0] : {src[22:0], 29'd0};
        e_max = dbl ? (e == 11'h7FF) : (e[7:0] == 8'hFF);
        ex    = {2'd0, e} - (dbl ? 13'd1023 : 13'd127);
        if (e_max) return {1'b0, (f != 52'd0), (f == 52'd0), 1'b0, 65'd0};
        if (e == 11'd0 && f == 52'd0) return {1'b0, 3'b001, 65'd0};
        if (e == 11'd0) return {1'b1, 3'b000, 13'd0, f};
        return {1'b0, 3'b000, ex, f};
    endfunction

    // Decode the incoming request operands
    always_comb begin
        dec_a = classify(in_double, in_src_a);
        dec_b = in_sqrt ? 69'd0 : classify(in_double, in_src_b);
        sgn_a = in_double ? in_src_a[63] : in_src_a[31];
        sgn_b = in_double ? in_src_b[63] : in_src_b[31];
        exp_base = double_q ? 13'h1C01 : 13'h1F81;
    end

`ifdef FDSU_PRENORM_DUAL_EN
    logic [12:0] bin_a, bin_b;
    logic [51:0] shf_a, shf_b;

    pa_fdsu_prenorm_norm u_norm_a (
        .frac_num       (frac_a_q),
        .frac_bin_val   (bin_a),
        .fanc_shift_num (shf_a)
    );

    pa_fdsu_prenorm_norm u_norm_b (
        .frac_num       (frac_b_q),
        .frac_bin_val   (bin_b),
        .fanc_shift_num (shf_b)
    );
`else
    logic [51:0] norm_in;
    logic [12:0] bin_v;
    logic [51:0] shf_v;

    assign norm_in = (state_q == NORM_B) ? frac_b_q : frac_a_q;

    pa_fdsu_prenorm_norm u_norm (
        .frac_num       (norm_in),
        .frac_bin_val   (bin_v),
        .fanc_shift_num (shf_v)
    );
`endif

    // Next-state and datapath updates for capture, normalize and hand-off
    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sqrt_d   = sqrt_q;
        double_d = double_q;
        sub_a_d  = sub_a_q;
        sub_b_d  = sub_b_q;
        exp_a_d  = exp_a_q;
        exp_b_d  = exp_b_q;
        frac_a_d = frac_a_q;
        frac_b_d = frac_b_q;
        cls_a_d  = cls_a_q;
        cls_b_d  = cls_b_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sqrt_d   = in_sqrt;
                    double_d = in_double;
                    sign_d   = in_sqrt ? sgn_a : (sgn_a ^ sgn_b);
                    sub_a_d  = dec_a[68];
                    sub_b_d  = dec_b[68];
                    cls_a_d  = dec_a[67:65];
                    cls_b_d  = dec_b[67:65];
                    exp_a_d  = dec_a[64:52];
                    exp_b_d  = dec_b[64:52];
                    frac_a_d = dec_a[51:0];
                    frac_b_d = dec_b[51:0];
`ifdef FDSU_PRENORM_DUAL_EN
                    state_d = (dec_a[68] | dec_b[68]) ? NORM : DONE;
`else
                    state_d = dec_a[68] ? NORM_A :
                              dec_b[68] ? NORM_B : DONE;
`endif
                end
            end
`ifdef FDSU_PRENORM_DUAL_EN
            NORM: begin
                if (sub_a_q) begin
                    exp_a_d  = exp_base + bin_a;
                    frac_a_d = shf_a << 1;
                end
                if (sub_b_q) begin
                    exp_b_d  = exp_base + bin_b;
                    frac_b_d = shf_b << 1;
                end
                state_d = DONE;
            end
`else
            NORM_A: begin
                exp_a_d  = exp_base + bin_v;
                frac_a_d = shf_v << 1;
                state_d  = sub_b_q ? NORM_B : DONE;
            end
            NORM_B: begin
                exp_b_d  = exp_base + bin_v;
                frac_b_d = shf_v << 1;
                state_d  = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d  = IDLE;
            sign_d   = 1'b0;
            sqrt_d   = 1'b0;
            double_d = 1'b0;
            sub_a_d  = 1'b0;
            sub_b_d  = 1'b0;
            exp_a_d  = 13'd0;
            exp_b_d  = 13'd0;
            frac_a_d = 52'd0;
            frac_b_d = 52'd0;
            cls_a_d  = 3'd0;
            cls_b_d  = 3'd0;
        end
        valid_d = (state_d == DONE);
    end

    // State and result registers, cleared by the asynchronous reset
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            sign_q   <= 1'b0;
            sqrt_q   <= 1'b0;
            double_q <= 1'b0;
            sub_a_q  <= 1'b0;
            sub_b_q  <= 1'b0;
            exp_a_q  <= 13'd0;
            exp_b_q  <= 13'd0;
            frac_a_q <= 52'd0;
            frac_b_q <= 52'd0;
            cls_a_q  <= 3'd0;
            cls_b_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            sign_q   <= sign_d;
            sqrt_q   <= sqrt_d;
            double_q <= double_d;
            sub_a_q  <= sub_a_d;
            sub_b_q  <= sub_b_d;
            exp_a_q  <= exp_a_d;
            exp_b_q  <= exp_b_d;
            frac_a_q <= frac_a_d;
            frac_b_q <= frac_b_d;
            cls_a_q  <= cls_a_d;
            cls_b_q  <= cls_b_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = valid_q;
    assign out_sign   = sign_q;
    assign out_sqrt   = sqrt_q;
    assign out_double = double_q;
    assign out_exp_a  = exp_a_q;
    assign out_exp_b  = exp_b_q;
    assign out_frac_a = frac_a_q;
    assign out_frac_b = frac_b_q;
    assign out_cls_a  = cls_a_q;
    assign out_cls_b  = cls_b_q;

endmodule

// File: doc/pa_fdsu_prenorm.md
# pa_fdsu_prenorm

Operand pre-normalization stage of the FDSU divide/sqrt unit. It accepts one divide or sqrt request and classifies both operands. Each subnormal operand is normalized through the shared 52-bit leading-one normalizer, so every operand leaves with a 1.f fraction and an unbiased 13-bit signed exponent. The result is handed to the SRT iteration stage over a valid/ready handshake.

## Interface
- No parameters; widths fixed (52-bit fraction, 13-bit exponent).
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, asynchronous, active-low; the only clock and reset
- flush  in  1  synchronous kill of any in-flight request
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_sqrt  in  1  1 = sqrt(a); 0 = a/b
- in_double  in  1  1 = binary64 in src[63:0]; 0 = binary32 in src[31:0]
- in_src_a, in_src_b  in  64 each  raw IEEE operands; b is ignored for sqrt
- out_valid  out  1  normalized operands valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  a.sign ^ b.sign for divide; a.sign for sqrt
- out_sqrt, out_double  out  1 each  captured opcode bits
- out_exp_a, out_exp_b  out  13 each  unbiased two's-complement exponent
- out_frac_a, out_frac_b  out  52 each  fraction bits below the hidden 1, MSB-aligned
- out_cls_a, out_cls_b  out  3 each  {nan, inf, zero}

## Operation
- FSM states: IDLE, NORM_A, NORM_B, DONE.
- in_ready = (state == IDLE).
- Request capture: on in_valid & in_ready, capture opcode and class.
- Fraction alignment into frac_num[51:0]:
  - binary64: the 52-bit field.
  - binary32: frac[22:0] placed in [51:29], zeros below.
- Normal operand, computed at capture:
  - exp = E − 1023 (binary64) or E − 127 (binary32).
  - frac = frac_num.
- Subnormal operand (E == 0, frac != 0), computed in its NORM state using the normalizer:
  - exp = −1023 (or −127) + frac_bin_val.
  - frac = {fanc_shift_num[50:0], 1'b0}.
- Zero, inf and NaN operands:
  - cls bit set, exp = 0, frac = 0.
  - No normalization cycle spent.
- Transitions from IDLE on accept:
  - a is subnormal → NORM_A.
  - else b is subnormal and in_sqrt = 0 → NORM_B.
  - otherwise → DONE.
- NORM_A → NORM_B if b needs normalization (divide only), else DONE.
- NORM_B → DONE.
- DONE: out_valid = 1. All out_* stay stable while out_ready = 0. Handshake → IDLE.
- flush: any state → IDLE next cycle; out_valid deasserts at that edge; captured data discarded.
- flush has priority over in_valid and over the out handshake in the same cycle.
- Reset (asynchronous, any time, including mid-NORM or DONE):
  - state = IDLE, out_valid = 0, in_ready = 1.
  - All data and class outputs = 0.
- Exponent arithmetic: 13-bit two's complement, no overflow possible. Range is [−1074, +1023].

## Timing
- Request accepted in cycle 0.
- out_valid rises at:
  - cycle 1 if no operand needs normalization;
  - cycle 2 if one operand needs normalization;
  - cycle 3 if both operands need normalization (divide only).
- Throughput: one request per (latency + 1) cycles minimum. No overlap, since in_ready is low outside IDLE.
- in_ready returns high the cycle after the out handshake, or after flush.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

## Configuration
- FDSU_PRENORM_DUAL_EN defined:
  - Two normalizer instances.
  - NORM_A and NORM_B merge into a single NORM state that normalizes both operands in one cycle.
  - Any-subnormal latency = 2.
- Undefined:
  - One shared normalizer, muxed between a and b.
  - Serial NORM_A/NORM_B as above.
- Interface, results and flush/reset behaviour are identical either way; only latency differs.

## Test plan
- Divide, binary64, a = 0x3FF0000000000000, b = 0x4000000000000000:
  - out_valid at cycle 1.
  - exp_a = 0x0000, exp_b = 0x0001.
  - frac_a = frac_b = 0, sign = 0, cls = 0.
- Divide, a = 0x0000000000000001, b = 1.0:
  - exp_a = 0x1BCE (−1074), frac_a = 0.
  - out_valid at cycle 2 in both configurations.
- Divide, a = 0x0008000000000000, b = 0x8004000000000000:
  - exp_a = 0x1C01, exp_b = 0x1C00, sign = 1.
  - out_valid at cycle 3 without the macro, cycle 2 with it.
- Sqrt, binary32, a = 0x00000001, b = 0x00000001:
  - exp_a = 0x1F6B (−149).
  - No NORM_B cycle; out_valid at cycle 2.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles in DONE → outputs stable, in_ready = 0.
  - Raise out_ready → in_ready = 1 the next cycle.
- Flush and reset:
  - Flush in NORM_A → IDLE next cycle; out_valid never rises.
  - Assert cpurst_b low mid-DONE → out_valid drops to 0 without a clock edge.
  - a = +0 → cls_a = 3'b001 with no normalization cycle.
